// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler feeding per-channel DAC codes to a single I2C writer, with
// coalescing shadow registers, periodic refresh of loaded channels and start-timeout detection.
module dac_update_scheduler #(
    parameter int unsigned CH_W           = 1,
    parameter int unsigned VALUE_W        = 12,
    parameter int unsigned REFRESH_CYCLES = 0,
    parameter int unsigned START_TIMEOUT  = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(2**CH_W)-1:0]           ch_req,
    input  logic [(2**CH_W)*VALUE_W-1:0]   ch_value,
    output logic [(2**CH_W)-1:0]           ch_pending,
    output logic                           wr_enable,
    output logic [CH_W-1:0]                wr_channel,
    output logic [VALUE_W-1:0]             wr_value,
    input  logic                           wr_busy,
    output logic                           done_valid,
    output logic [CH_W-1:0]                done_channel,
    output logic                           timeout_err,
    input  logic                           err_clr,
    output logic                           busy
);

    localparam int unsigned NUM_CH = 2**CH_W;
    localparam int unsigned TO_W   = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e               state_q, state_d;
    logic [VALUE_W-1:0]   shadow_q [NUM_CH];
    logic [VALUE_W-1:0]   shadow_d [NUM_CH];
    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [NUM_CH-1:0]    loaded_q, loaded_d;
    logic [CH_W-1:0]      last_grant_q, last_grant_d;
    logic [CH_W-1:0]      wr_channel_q, wr_channel_d;
    logic [VALUE_W-1:0]   wr_value_q, wr_value_d;
    logic                 wr_enable_q;
    logic                 done_q, done_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 timeout_fire;
    logic                 refresh_tick;
    logic                 grant_found;
    logic [CH_W-1:0]      grant_ch;
    logic [CH_W-1:0]      cand;

    if (REFRESH_CYCLES != 0) begin : g_refresh
        localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        logic [RW-1:0] rcnt_q;

        assign refresh_tick = (rcnt_q == RW'(REFRESH_CYCLES - 1));

        always_ff @(posedge clk) begin
            if (rst || refresh_tick) begin
                rcnt_q <= '0;
            end else begin
                rcnt_q <= rcnt_q + RW'(1);
            end
        end
    end else begin : g_no_refresh
        assign refresh_tick = 1'b0;
    end

    // First pending channel after the last grant, wrapping; CH_W-bit sum wraps naturally.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = last_grant_q + CH_W'(k);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        loaded_d     = loaded_q;
        last_grant_d = last_grant_q;
        wr_channel_d = wr_channel_q;
        wr_value_d   = wr_value_q;
        to_cnt_d     = to_cnt_q;
        done_d       = 1'b0;
        timeout_fire = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found && !wr_busy) begin
                    wr_channel_d        = grant_ch;
                    wr_value_d          = shadow_q[grant_ch];
                    pending_d[grant_ch] = 1'b0;
                    last_grant_d        = grant_ch;
                    to_cnt_d            = '0;
                    state_d             = StIssue;
                end
            end
            StIssue: begin
                if (wr_busy) begin
                    state_d = StWaitDone;
                end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                    timeout_fire            = 1'b1;
                    pending_d[wr_channel_q] = 1'b1;
                    state_d                 = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StWaitDone: begin
                if (!wr_busy) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (refresh_tick) begin
            pending_d = pending_d | loaded_q;
        end

        // Requests are applied last so they win over a same-cycle grant clear.
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_req[i]) begin
                shadow_d[i]  = ch_value[i*VALUE_W +: VALUE_W];
                pending_d[i] = 1'b1;
                loaded_d[i]  = 1'b1;
            end
        end

        if (timeout_fire) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            shadow_q      <= '{default: '0};
            pending_q     <= '0;
            loaded_q      <= '0;
            last_grant_q  <= '1;
            wr_channel_q  <= '0;
            wr_value_q    <= '0;
            wr_enable_q   <= 1'b0;
            done_q        <= 1'b0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            loaded_q      <= loaded_d;
            last_grant_q  <= last_grant_d;
            wr_channel_q  <= wr_channel_d;
            wr_value_q    <= wr_value_d;
            wr_enable_q   <= (state_d == StIssue);
            done_q        <= done_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ch_pending   = pending_q;
    assign wr_enable    = wr_enable_q;
    assign wr_channel   = wr_channel_q;
    assign wr_value     = wr_value_q;
    assign done_valid   = done_q;
    assign done_channel = wr_channel_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != StIdle) || (|pending_q);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: directed scenarios plus random traffic checked against a
// transaction-level round-robin model; a second instance exercises the refresh period.
module tb_dac_update_scheduler;

    localparam int NUM_CH = 2;
    localparam int VW     = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: no refresh, short start timeout
    logic                 rst_a, err_clr_a, wr_busy_a;
    logic [NUM_CH-1:0]    ch_req_a, ch_pending_a;
    logic [NUM_CH*VW-1:0] ch_value_a;
    logic                 wr_enable_a, done_valid_a, timeout_err_a, busy_a;
    logic [0:0]           wr_channel_a, done_channel_a;
    logic [VW-1:0]        wr_value_a;

    // Instance B: refresh every 100 cycles
    logic                 rst_b, err_clr_b, wr_busy_b;
    logic [NUM_CH-1:0]    ch_req_b, ch_pending_b;
    logic [NUM_CH*VW-1:0] ch_value_b;
    logic                 wr_enable_b, done_valid_b, timeout_err_b, busy_b;
    logic [0:0]           wr_channel_b, done_channel_b;
    logic [VW-1:0]        wr_value_b;

    dac_update_scheduler #(
        .CH_W(1), .VALUE_W(VW), .REFRESH_CYCLES(0), .START_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .rst(rst_a), .ch_req(ch_req_a), .ch_value(ch_value_a),
        .ch_pending(ch_pending_a), .wr_enable(wr_enable_a), .wr_channel(wr_channel_a),
        .wr_value(wr_value_a), .wr_busy(wr_busy_a), .done_valid(done_valid_a),
        .done_channel(done_channel_a), .timeout_err(timeout_err_a), .err_clr(err_clr_a),
        .busy(busy_a)
    );

    dac_update_scheduler #(
        .CH_W(1), .VALUE_W(VW), .REFRESH_CYCLES(100), .START_TIMEOUT(1024)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ch_req(ch_req_b), .ch_value(ch_value_b),
        .ch_pending(ch_pending_b), .wr_enable(wr_enable_b), .wr_channel(wr_channel_b),
        .wr_value(wr_value_b), .wr_busy(wr_busy_b), .done_valid(done_valid_b),
        .done_channel(done_channel_b), .timeout_err(timeout_err_b), .err_clr(err_clr_b),
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Writer model A: delay then busy for a hold period; can be stalled or made unresponsive.
    logic wb_a = 1'b0, ext_busy = 1'b0, writer_dead = 1'b0, w_rand = 1'b0;
    int   w_st = 0, w_cnt = 0;
    assign wr_busy_a = wb_a | ext_busy;
    always @(posedge clk) begin
        case (w_st)
            0: if (wr_enable_a && !writer_dead && !ext_busy) begin
                w_cnt <= w_rand ? int'($urandom_range(3, 0)) : 2;
                w_st  <= 1;
            end
            1: if (w_cnt == 0) begin
                wb_a  <= 1'b1;
                w_cnt <= w_rand ? int'($urandom_range(5, 0)) : 19;
                w_st  <= 2;
            end else w_cnt <= w_cnt - 1;
            2: if (w_cnt == 0) begin
                wb_a <= 1'b0;
                w_st <= 0;
            end else w_cnt <= w_cnt - 1;
            default: w_st <= 0;
        endcase
    end

    // Writer model B: fixed short transfer
    logic wb_b = 1'b0;
    int   wb_st = 0, wb_cnt = 0;
    assign wr_busy_b = wb_b;
    always @(posedge clk) begin
        case (wb_st)
            0: if (wr_enable_b) begin wb_cnt <= 1; wb_st <= 1; end
            1: if (wb_cnt == 0) begin wb_b <= 1'b1; wb_cnt <= 4; wb_st <= 2; end
               else wb_cnt <= wb_cnt - 1;
            2: if (wb_cnt == 0) begin wb_b <= 1'b0; wb_st <= 0; end
               else wb_cnt <= wb_cnt - 1;
            default: wb_st <= 0;
        endcase
    end

    function automatic int rr_pick(input logic [NUM_CH-1:0] p, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (p[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    // Reference model for A: shadow/pending/loaded sets, round-robin pick at each new transfer
    logic [VW-1:0]     m_sh [NUM_CH];
    logic [NUM_CH-1:0] m_pend = '0, m_load = '0;
    int                m_last = NUM_CH - 1, inflight = -1;
    logic              prev_en = 1'b0, m_en = 1'b1;
    int                n_start = 0, n_done = 0, last_done_ch = -1;

    always @(posedge clk) begin
        logic [NUM_CH-1:0]    c_req;
        logic [NUM_CH*VW-1:0] c_val;
        logic                 c_rst;
        int                   g;
        c_req = ch_req_a;
        c_val = ch_value_a;
        c_rst = rst_a;
        #2;
        if (c_rst) begin
            m_pend = '0;
            m_load = '0;
            for (int i = 0; i < NUM_CH; i++) m_sh[i] = '0;
            m_last   = NUM_CH - 1;
            inflight = -1;
        end else begin
            if (wr_enable_a && !prev_en) begin
                n_start++;
                if (m_en) begin
                    g = rr_pick(m_pend, m_last);
                    check("grant_channel", 32'(wr_channel_a), g);
                    if (g >= 0) begin
                        check("grant_value", 32'(wr_value_a), 32'(m_sh[g]));
                        m_pend[g] = 1'b0;
                        m_last    = g;
                    end
                    inflight = g;
                end
            end
            if (done_valid_a) begin
                n_done++;
                last_done_ch = int'(done_channel_a);
                if (m_en) begin
                    check("done_channel", 32'(done_channel_a), inflight);
                    inflight = -1;
                end
            end
            if (m_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (c_req[i]) begin
                        m_sh[i]   = c_val[i*VW +: VW];
                        m_pend[i] = 1'b1;
                        m_load[i] = 1'b1;
                    end
                end
                check("pending", 32'(ch_pending_a), 32'(m_pend));
            end
        end
        prev_en = wr_enable_a;
    end

    // Transfer log for B
    int            b_cyc_q [$];
    int            b_ch_q  [$];
    logic [VW-1:0] b_val_q [$];
    logic          prev_en_b = 1'b0;
    always @(posedge clk) begin
        #2;
        if (wr_enable_b && !prev_en_b) begin
            b_cyc_q.push_back(cyc);
            b_ch_q.push_back(int'(wr_channel_b));
            b_val_q.push_back(wr_value_b);
        end
        prev_en_b = wr_enable_b;
    end

    task automatic wait_rise(input int lim, input string tag);
        int k = 0;
        while (!wr_enable_a && k < lim) begin tick(1); k++; end
        check(tag, 32'(k < lim), 1);
    endtask

    task automatic wait_fall(input int lim, output int k);
        k = 0;
        while (wr_enable_a && k < lim) begin tick(1); k++; end
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int k = 0;
        while ((busy_a || wr_busy_a) && k < lim) begin tick(1); k++; end
        check(tag, 32'(k < lim), 1);
        tick(2);
    endtask

    initial begin
        int d0, s0, k;
        rst_a = 1'b1; rst_b = 1'b1; err_clr_a = 1'b0; err_clr_b = 1'b0;
        ch_req_a = '0; ch_value_a = '0; ch_req_b = '0; ch_value_b = '0;
        tick(3);
        check("rst_wr_enable", 32'(wr_enable_a), 0);
        check("rst_wr_channel", 32'(wr_channel_a), 0);
        check("rst_wr_value", 32'(wr_value_a), 0);
        check("rst_done_valid", 32'(done_valid_a), 0);
        check("rst_timeout_err", 32'(timeout_err_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_pending", 32'(ch_pending_a), 0);
        check("rst_b_outputs", 32'({wr_enable_b, busy_b, ch_pending_b, wr_value_b}), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(1);

        ch_req_b = 2'b10; ch_value_b = {12'h3FF, 12'h000};
        tick(1);
        ch_req_b = '0;

        // Single write
        d0 = n_done;
        ch_req_a = 2'b01; ch_value_a = {12'h000, 12'hABC};
        tick(1);
        ch_req_a = '0;
        check("req_to_pending", 32'(ch_pending_a), 2'b01);
        tick(1);
        check("issue_enable", 32'(wr_enable_a), 1);
        check("issue_channel", 32'(wr_channel_a), 0);
        check("issue_value", 32'(wr_value_a), 12'hABC);
        check("issue_clears_pending", 32'(ch_pending_a), 0);
        wait_idle(100, "single_finish");
        check("single_done_count", n_done - d0, 1);
        check("single_done_channel", last_done_ch, 0);
        check("single_busy_after", 32'(busy_a), 0);

        // Coalescing behind an externally busy writer
        ext_busy = 1'b1;
        ch_req_a = 2'b10; ch_value_a = {12'h111, 12'h000};
        tick(1);
        ch_req_a = '0;
        tick(1);
        ch_req_a = 2'b10; ch_value_a = {12'h222, 12'h000};
        tick(1);
        ch_req_a = '0;
        tick(5);
        check("coalesce_held", 32'(wr_enable_a), 0);
        check("coalesce_pending", 32'(ch_pending_a), 2'b10);
        s0 = n_start;
        ext_busy = 1'b0;
        wait_rise(20, "coalesce_start");
        check("coalesce_channel", 32'(wr_channel_a), 1);
        check("coalesce_value", 32'(wr_value_a), 12'h222);
        wait_idle(100, "coalesce_finish");
        check("coalesce_writes", n_start - s0, 1);

        // Round-robin with both channels re-requested during every transfer
        ch_req_a = 2'b11; ch_value_a = 24'($urandom);
        tick(1);
        ch_req_a = '0;
        for (int t = 0; t < 6; t++) begin
            wait_rise(60, "rr_start");
            check("rr_order", 32'(wr_channel_a), t % 2);
            tick(2);
            ch_req_a = 2'b11; ch_value_a = 24'($urandom);
            tick(1);
            ch_req_a = '0;
            wait_fall(20, k);
        end
        wait_idle(200, "rr_drain");

        // Random traffic against the model
        w_rand = 1'b1;
        d0 = n_done; s0 = n_start;
        for (int t = 0; t < 400; t++) begin
            ch_req_a[0] = ($urandom_range(5, 0) == 0);
            ch_req_a[1] = ($urandom_range(5, 0) == 0);
            ch_value_a  = 24'($urandom);
            tick(1);
        end
        ch_req_a = '0;
        wait_idle(300, "rand_drain");
        check("rand_pending_empty", 32'(ch_pending_a), 0);
        check("rand_starts_eq_dones", n_start - s0, n_done - d0);
        w_rand = 1'b0;

        // Start timeout with an unresponsive writer
        m_en = 1'b0; writer_dead = 1'b1;
        ch_req_a = 2'b01; ch_value_a = 24'h000123;
        tick(1);
        ch_req_a = '0;
        wait_rise(10, "to_start");
        wait_fall(20, k);
        check("to_enable_cycles", k, 8);
        check("to_err_set", 32'(timeout_err_a), 1);
        check("to_pending_restored", 32'(ch_pending_a[0]), 1);
        tick(1);
        check("to_retry", 32'(wr_enable_a), 1);
        check("to_retry_channel", 32'(wr_channel_a), 0);
        err_clr_a = 1'b1;
        tick(1);
        check("to_err_clear", 32'(timeout_err_a), 0);
        wait_fall(20, k);
        check("to_err_beats_clear", 32'(timeout_err_a), 1);
        err_clr_a = 1'b0;
        rst_a = 1'b1;
        tick(2);
        rst_a = 1'b0; writer_dead = 1'b0;
        tick(1);
        m_en = 1'b1;

        // Reset while waiting for the writer to finish
        ch_req_a = 2'b10; ch_value_a = {12'h5A5, 12'h000};
        tick(1);
        ch_req_a = '0;
        wait_rise(10, "rstw_start");
        wait_fall(20, k);
        tick(3);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        check("rstw_wr_enable", 32'(wr_enable_a), 0);
        check("rstw_wr_channel", 32'(wr_channel_a), 0);
        check("rstw_wr_value", 32'(wr_value_a), 0);
        check("rstw_done_valid", 32'(done_valid_a), 0);
        check("rstw_busy", 32'(busy_a), 0);
        check("rstw_pending", 32'(ch_pending_a), 0);
        d0 = n_done;
        tick(30);
        check("rstw_no_done", n_done - d0, 0);

        // Refresh instance: only channel 1, one write per refresh period
        check("refresh_count", 32'(b_cyc_q.size() >= 4), 1);
        for (int i = 0; i < b_cyc_q.size(); i++) begin
            check("refresh_channel", b_ch_q[i], 1);
            check("refresh_value", 32'(b_val_q[i]), 12'h3FF);
            if (i >= 2) check("refresh_period", b_cyc_q[i] - b_cyc_q[i-1], 100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
